// File: rtl/perceptron_controller.sv
// Control FSM for a two-input perceptron trainer. It walks the sample memory
// once per epoch, strobes the datapath registers, and stops when an epoch
// finishes without errors or the epoch limit is reached.
module perceptron_controller #(
    parameter int NUM_SAMPLES = 100,
    parameter int ADDR_W      = 7,
    parameter int MAX_EPOCHS  = 255,
    parameter int EPOCH_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               eqFlag,
    input  logic               endFlag,
    output logic               ldX1,
    output logic               ldX2,
    output logic               ldt,
    output logic               ldYin,
    output logic               ldW1,
    output logic               ldW2,
    output logic               ldB,
    output logic               initW1,
    output logic               initW2,
    output logic               initB,
    output logic               ldEndFlag,
    output logic               initEndFlag,
    output logic [ADDR_W-1:0]  sampleAddr,
    output logic [EPOCH_W-1:0] epochCount,
    output logic               busy,
    output logic               done,
    output logic               converged
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_EPOCH_START,
        S_LOAD,
        S_CALC,
        S_CHECK,
        S_UPDATE,
        S_NEXT,
        S_EPOCH_END,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCHS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               conv_q, conv_d;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            epoch_q <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            epoch_q <= epoch_d;
            conv_q  <= conv_d;
        end
    end

    // Next-state logic; sampleAddr is cleared on every entry into EPOCH_START.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        epoch_d = epoch_q;
        conv_d  = conv_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    conv_d  = 1'b0;
                    epoch_d = '0;
                end
            end
            S_INIT: begin
                state_d = S_EPOCH_START;
                addr_d  = '0;
            end
            S_EPOCH_START: state_d = S_LOAD;
            S_LOAD:        state_d = S_CALC;
            S_CALC:        state_d = S_CHECK;
            S_CHECK:       state_d = eqFlag ? S_NEXT : S_UPDATE;
            S_UPDATE:      state_d = S_NEXT;
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_EPOCH_END;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_EPOCH_END: begin
                if (endFlag) begin
                    state_d = S_DONE;
                    conv_d  = 1'b1;
                end else if (epoch_q == LAST_EPOCH) begin
                    state_d = S_DONE;
                    conv_d  = 1'b0;
                end else begin
                    epoch_d = epoch_q + 1'b1;
                    addr_d  = '0;
                    state_d = S_EPOCH_START;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode of datapath strobes and status from the current state.
    always_comb begin
        ldX1        = 1'b0;
        ldX2        = 1'b0;
        ldt         = 1'b0;
        ldYin       = 1'b0;
        ldW1        = 1'b0;
        ldW2        = 1'b0;
        ldB         = 1'b0;
        initW1      = 1'b0;
        initW2      = 1'b0;
        initB       = 1'b0;
        ldEndFlag   = 1'b0;
        initEndFlag = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        unique case (state_q)
            S_INIT: begin
                initW1 = 1'b1;
                initW2 = 1'b1;
                initB  = 1'b1;
            end
            S_EPOCH_START: initEndFlag = 1'b1;
            S_LOAD: begin
                ldX1 = 1'b1;
                ldX2 = 1'b1;
                ldt  = 1'b1;
            end
            S_CALC:  ldYin     = 1'b1;
            S_CHECK: ldEndFlag = 1'b1;
            S_UPDATE: begin
                ldW1 = 1'b1;
                ldW2 = 1'b1;
                ldB  = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign sampleAddr = addr_q;
    assign epochCount = epoch_q;
    assign converged  = conv_q;

endmodule

// File: tb/tb_perceptron_controller.sv
// Directed bench for perceptron_controller: a 4-sample / 3-epoch instance
// driven by a tiny datapath model, plus a 1-sample instance.
module tb_perceptron_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- DUT A: NUM_SAMPLES=4, MAX_EPOCHS=3 ----------------
    logic       rst, start, eqFlag, endFlag;
    logic       ldX1, ldX2, ldt, ldYin, ldW1, ldW2, ldB;
    logic       initW1, initW2, initB, ldEndFlag, initEndFlag;
    logic [1:0] sampleAddr;
    logic [1:0] epochCount;
    logic       busy, done, converged;
    logic [11:0] strobes;
    assign strobes = {ldX1, ldX2, ldt, ldYin, ldW1, ldW2, ldB,
                      initW1, initW2, initB, ldEndFlag, initEndFlag};

    perceptron_controller #(
        .NUM_SAMPLES(4),
        .ADDR_W     (2),
        .MAX_EPOCHS (3),
        .EPOCH_W    (2)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .eqFlag     (eqFlag),
        .endFlag    (endFlag),
        .ldX1       (ldX1),
        .ldX2       (ldX2),
        .ldt        (ldt),
        .ldYin      (ldYin),
        .ldW1       (ldW1),
        .ldW2       (ldW2),
        .ldB        (ldB),
        .initW1     (initW1),
        .initW2     (initW2),
        .initB      (initB),
        .ldEndFlag  (ldEndFlag),
        .initEndFlag(initEndFlag),
        .sampleAddr (sampleAddr),
        .epochCount (epochCount),
        .busy       (busy),
        .done       (done),
        .converged  (converged)
    );

    // ---------------- DUT B: NUM_SAMPLES=1, MAX_EPOCHS=2 ----------------
    logic       start_b;
    logic       ldX1_b, ldX2_b, ldt_b, ldYin_b, ldW1_b, ldW2_b, ldB_b;
    logic       initW1_b, initW2_b, initB_b, ldEndFlag_b, initEndFlag_b;
    logic [0:0] sampleAddr_b;
    logic [0:0] epochCount_b;
    logic       busy_b, done_b, converged_b;

    perceptron_controller #(
        .NUM_SAMPLES(1),
        .ADDR_W     (1),
        .MAX_EPOCHS (2),
        .EPOCH_W    (1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .eqFlag     (1'b1),
        .endFlag    (1'b0),
        .ldX1       (ldX1_b),
        .ldX2       (ldX2_b),
        .ldt        (ldt_b),
        .ldYin      (ldYin_b),
        .ldW1       (ldW1_b),
        .ldW2       (ldW2_b),
        .ldB        (ldB_b),
        .initW1     (initW1_b),
        .initW2     (initW2_b),
        .initB      (initB_b),
        .ldEndFlag  (ldEndFlag_b),
        .initEndFlag(initEndFlag_b),
        .sampleAddr (sampleAddr_b),
        .epochCount (epochCount_b),
        .busy       (busy_b),
        .done       (done_b),
        .converged  (converged_b)
    );

    // Datapath model policy: which (epoch, sample) mismatches, and from
    // which epoch onward the epoch reports "no errors".
    int bad_epoch;
    int bad_addr;
    int end_from_epoch;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dp();
        eqFlag  = !(int'(epochCount) == bad_epoch && int'(sampleAddr) == bad_addr);
        endFlag = (int'(epochCount) >= end_from_epoch);
    endtask

    // Launches a run on DUT A and follows it up to the DONE cycle.
    task automatic run_a(input bit hold, output int cyc, output int upd,
                         output int loads, output int addr_err,
                         output int proto_err, output int ep_done,
                         output int conv, output int done_seen);
        int exp_addr;
        cyc = 0; upd = 0; loads = 0; addr_err = 0; proto_err = 0;
        ep_done = -1; conv = -1; done_seen = 0; exp_addr = 0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check_eq("init_after_start", int'({initW1, initW2, initB}), 7);
        check_eq("epoch_zero_in_init", int'(epochCount), 0);
        for (int i = 0; i < 500 && done_seen == 0; i++) begin
            drive_dp();
            if (busy) cyc++;
            if (ldW1) upd++;
            if (initEndFlag) exp_addr = 0;
            if (ldX1) begin
                loads++;
                if (int'(sampleAddr) != exp_addr) addr_err++;
                exp_addr++;
            end
            if ((initW1 | initW2 | initB) && (ldW1 | ldW2 | ldB)) proto_err++;
            if (initEndFlag && ldEndFlag) proto_err++;
            if ((ldW1 != ldW2) || (ldW1 != ldB)) proto_err++;
            if (done) begin
                done_seen = 1;
                ep_done   = int'(epochCount);
                conv      = int'(converged);
            end else begin
                tick();
            end
        end
        check_eq("run_done_seen", done_seen, 1);
    endtask

    int cyc, upd, loads, aerr, perr, epd, conv, dseen, cnt;

    initial begin
        rst = 1'b1; start = 1'b0; eqFlag = 1'b1; endFlag = 1'b0; start_b = 1'b0;
        bad_epoch = -1; bad_addr = -1; end_from_epoch = 0;
        tick();
        tick();
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_strobes", int'(strobes), 0);
        check_eq("rst_addr", int'(sampleAddr), 0);
        check_eq("rst_epoch", int'(epochCount), 0);
        check_eq("rst_conv", int'(converged), 0);
        rst = 1'b0;
        tick();

        // Clean run: every sample correct, epoch 0 error-free.
        run_a(1'b0, cyc, upd, loads, aerr, perr, epd, conv, dseen);
        check_eq("t1_cycles", cyc, 20);
        check_eq("t1_updates", upd, 0);
        check_eq("t1_loads", loads, 4);
        check_eq("t1_addr_seq", aerr, 0);
        check_eq("t1_protocol", perr, 0);
        check_eq("t1_epoch", epd, 0);
        check_eq("t1_conv", conv, 1);
        tick();
        check_eq("t1_idle_after_done", int'(busy), 0);
        check_eq("t1_conv_held", int'(converged), 1);

        // One mismatch on sample 2 of epoch 0; epoch 1 error-free.
        // INIT + epoch0 (2+4+4+5+4) + epoch1 (2+16) + DONE.
        bad_epoch = 0; bad_addr = 2; end_from_epoch = 1;
        run_a(1'b0, cyc, upd, loads, aerr, perr, epd, conv, dseen);
        check_eq("t2_cycles", cyc, 1 + 19 + 18 + 1);
        check_eq("t2_updates", upd, 1);
        check_eq("t2_loads", loads, 8);
        check_eq("t2_addr_seq", aerr, 0);
        check_eq("t2_protocol", perr, 0);
        check_eq("t2_epoch", epd, 1);
        check_eq("t2_conv", conv, 1);
        tick();

        // Never converges: three full epochs then give up.
        bad_epoch = -1; bad_addr = -1; end_from_epoch = 99;
        run_a(1'b0, cyc, upd, loads, aerr, perr, epd, conv, dseen);
        check_eq("t3_cycles", cyc, 1 + 3 * 18 + 1);
        check_eq("t3_loads", loads, 12);
        check_eq("t3_addr_seq", aerr, 0);
        check_eq("t3_epoch", epd, 2);
        check_eq("t3_conv", conv, 0);
        tick();
        check_eq("t3_conv_held", int'(converged), 0);

        // start held high for the whole run: no restart mid-run, and a new
        // INIT only after one IDLE cycle following DONE.
        end_from_epoch = 0;
        run_a(1'b1, cyc, upd, loads, aerr, perr, epd, conv, dseen);
        check_eq("t4_cycles", cyc, 20);
        check_eq("t4_conv", conv, 1);
        tick();
        check_eq("t4_idle_gap", int'(busy), 0);
        tick();
        check_eq("t4_reinit", int'({initW1, initW2, initB}), 7);
        check_eq("t4_conv_cleared", int'(converged), 0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset during UPDATE of epoch 1 abandons the run.
        bad_epoch = 1; bad_addr = 1; end_from_epoch = 99;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200 && !(ldW1 && epochCount == 2'd1); i++) begin
            drive_dp();
            tick();
            cnt++;
        end
        check_eq("t5_reached_update", int'(ldW1 && epochCount == 2'd1), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_busy", int'(busy), 0);
        check_eq("t5_strobes", int'(strobes), 0);
        check_eq("t5_done", int'(done), 0);
        check_eq("t5_epoch", int'(epochCount), 0);
        check_eq("t5_addr", int'(sampleAddr), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        check_eq("t5_stays_idle", cnt, 0);

        // Reset wins over start.
        rst = 1'b1; start = 1'b1;
        tick();
        check_eq("t6_rst_priority", int'(busy), 0);
        rst = 1'b0; start = 1'b0;
        tick();
        check_eq("t6_still_idle", int'(busy), 0);

        // Re-run after the abandoned run starts cleanly from INIT.
        bad_epoch = -1; bad_addr = -1; end_from_epoch = 0;
        run_a(1'b0, cyc, upd, loads, aerr, perr, epd, conv, dseen);
        check_eq("t7_cycles", cyc, 20);
        check_eq("t7_epoch", epd, 0);
        check_eq("t7_conv", conv, 1);
        tick();

        // Single-sample instance: NEXT goes straight to EPOCH_END.
        // INIT + 2 epochs of (EPOCH_START+LOAD+CALC+CHECK+NEXT+EPOCH_END) + DONE.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0; loads = 0; aerr = 0; dseen = 0; epd = -1; conv = -1;
        for (int i = 0; i < 100 && dseen == 0; i++) begin
            if (busy_b) cyc++;
            if (ldX1_b) begin
                loads++;
                if (sampleAddr_b != 1'b0) aerr++;
            end
            if (done_b) begin
                dseen = 1;
                epd   = int'(epochCount_b);
                conv  = int'(converged_b);
            end else begin
                tick();
            end
        end
        check_eq("b_done_seen", dseen, 1);
        check_eq("b_cycles", cyc, 14);
        check_eq("b_loads", loads, 2);
        check_eq("b_addr", aerr, 0);
        check_eq("b_epoch", epd, 1);
        check_eq("b_conv", conv, 0);
        tick();
        check_eq("b_idle", int'(busy_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
